// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-clock enable, h/v counters, registered
// sync/active decode and line/frame strobes, all on the board clock.
module vga_timing_gen #(
  parameter int CW       = 10,
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic          pix_tick,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          video_on,
  output logic          vga_h_sync,
  output logic          vga_v_sync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT        = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT        = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          SYNC_ON      = 1'(SYNC_POL);
  localparam logic          SYNC_OFF     = ~SYNC_ON;

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          video_on_q, video_on_d;
  logic          h_sync_q, h_sync_d;
  logic          v_sync_q, v_sync_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          tick;
  logic          h_last;
  logic          v_last;

  // Pixel enable fires on the last divider phase; with CLK_DIV=1 the divider is always 0 so tick follows run.
  assign tick   = run && (div_q == DIV_LAST);
  // Compare with >= so an oversized counter can never run past the last position.
  assign h_last = (h_q >= H_LAST);
  assign v_last = (v_q >= V_LAST);

  // Next-state counters and decode; decoding from the next position keeps sync/active aligned with pix_x/pix_y.
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (run) begin
      div_d = (div_q >= DIV_LAST) ? '0 : div_q + 1'b1;
    end
    if (tick) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    video_on_d    = (h_d < H_ACT) && (v_d < V_ACT);
    h_sync_d      = ((h_d >= H_SYNC_START) && (h_d < H_SYNC_END)) ? SYNC_ON : SYNC_OFF;
    v_sync_d      = ((v_d >= V_SYNC_START) && (v_d < V_SYNC_END)) ? SYNC_ON : SYNC_OFF;
    line_start_d  = tick && h_last;
    frame_start_d = tick && h_last && v_last;
  end

  // State and registered outputs; reset lands on position (0,0) with syncs inactive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      h_q           <= '0;
      v_q           <= '0;
      video_on_q    <= 1'b1;
      h_sync_q      <= SYNC_OFF;
      v_sync_q      <= SYNC_OFF;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      video_on_q    <= video_on_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_tick    = tick;
  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign video_on    = video_on_q;
  assign vga_h_sync  = h_sync_q;
  assign vga_v_sync  = v_sync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator. Supersedes the fixed 640x480 sync generator and the free-running DIV_CLK tap used as the pixel clock in the game top level.
Generates an internal pixel-clock enable from the board clock, horizontal/vertical counters, sync pulses, the active-video flag and line/frame strobes, all from one clock domain.
Sits between the board clock and VGA_Graph / Buttons_Control. Those blocks run on clk and qualify their logic with pix_tick.

Parameters:
CW, 10, width of pix_x/pix_y; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)
CLK_DIV, 4, board clocks per pixel (1..16); 4 reproduces DIV_CLK[1] at 100 MHz
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 0, active sync level (0 = active-low)

Ports:
clk  input  1  board clock
reset  input  1  asynchronous, active-high reset
run  input  1  1 = timing advances; 0 = freeze all counters and outputs
pix_tick  output  1  one-clk pixel enable, high once every CLK_DIV clks while run=1
pix_x  output  CW  current horizontal count, 0..H_TOTAL-1
pix_y  output  CW  current vertical count, 0..V_TOTAL-1
video_on  output  1  1 when pix_x<H_ACTIVE and pix_y<V_ACTIVE
vga_h_sync  output  1  horizontal sync at SYNC_POL level during sync
vga_v_sync  output  1  vertical sync at SYNC_POL level during sync
line_start  output  1  one-clk pulse: counters just entered pix_x=0
frame_start  output  1  one-clk pulse: counters just entered (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Divider: div counts 0..CLK_DIV-1 on each clk with run=1 and wraps. pix_tick is combinational and equals (run && div==CLK_DIV-1). For CLK_DIV=1, pix_tick = run.
- On a clk edge with pix_tick=1:
  - If h = H_TOTAL-1: h wraps to 0 and v increments; v wraps to 0 at V_TOTAL-1.
  - Otherwise h increments.
- pix_x/pix_y are the h/v registers directly.
- video_on, vga_h_sync and vga_v_sync are registered. Each is decoded from the next-state h/v, so all three change on the same edge as pix_x/pix_y. Zero skew between position and decode.
- h-sync is active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
- v-sync is active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491).
- Output level = SYNC_POL when active, ~SYNC_POL otherwise.
- line_start / frame_start are registered and high for exactly one clk, on the edge where h (resp. h and v) transitions to 0 (resp. 0,0). line_start is also high with frame_start.
- run=0: div, h, v and all registered outputs hold. pix_tick, line_start and frame_start are 0.
- run low→high: resumes from the held div value. No extra or lost tick.
- Reset (async, any time, including mid-line):
  - div=0, pix_x=0, pix_y=0, video_on=1.
  - Syncs at ~SYNC_POL.
  - line_start=0, frame_start=0.
  - First pix_tick is CLK_DIV clks after reset release with run=1.
- Period: one line = H_TOTAL*CLK_DIV clks; one frame = H_TOTAL*V_TOTAL*CLK_DIV clks (1,680,000 at defaults).
- No illegal states: h/v never exceed TOTAL-1. Counters wider than needed must still wrap at TOTAL-1.

Test Plan:
- Reset mid-frame at h=300,v=200 with run=1 -> outputs immediately 0,0, video_on=1, syncs=1 (SYNC_POL=0); first pix_tick exactly 4 clks after reset release.
- Defaults, run=1 -> vga_h_sync low for exactly 96*4=384 clks, falling on the edge where pix_x becomes 656. video_on falls when pix_x becomes 640.
- Defaults, full frame -> frame_start pulses exactly 1,680,000 clks apart. line_start occurs 525 times per frame. vga_v_sync is low for 2*800*4=6400 clks starting at pix_y=490.
- run dropped at pix_x=100 for 50 clks, then raised -> pix_x stays 100 with no pix_tick; next increment lands at the original divider phase.
- CLK_DIV=1, SYNC_POL=1, H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 -> pix_tick constant high; line every 12 clks; frame every 84 clks; h-sync high at pix_x 9..10.
- Wrap corner (h=799,v=524) on pix_tick -> next edge gives (0,0) with frame_start=1, line_start=1, video_on=1 in the same cycle.
